// File: rtl/cov_erode.sv
// cov_erode: 3x3 binary erosion on the binarized VGA pixel stream.
//
// A centre pixel stays foreground (12'hfff) only when all nine pixels of its
// 3x3 neighbourhood are foreground. This strips isolated speckle before the
// dilation stage closes gaps.
//
// Ports
//   vga_clk        pixel clock (only clock)
//   rst_n          asynchronous active-low reset
//   pixel_x/y      raster coordinates of the incoming sample
//   erzhihua_data  binarized pixel; foreground when bits [23:16] are non-zero
//   erode_out      12'hfff for an eroded foreground centre, else 12'h000
//   erode_valid    erode_out carries a computed window result
//   erode_x/y      coordinates of the window centre for erode_out
//
// The result for sample (x,y) appears one clock later and describes centre
// (x-1,y-1). Frame-border centres are never marked valid.
module cov_erode #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [23:0] erzhihua_data,
    output logic [11:0] erode_out,
    output logic        erode_valid,
    output logic [9:0]  erode_x,
    output logic [9:0]  erode_y
);
    localparam int         AW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    logic          active;
    logic [AW-1:0] idx;
    logic          cur;
    logic          line_start;
    logic          win_ok;
    logic          hit;
    logic [2:0]    col;      // {row y-2, row y-1, row y} at column x
    logic [2:0]    c1, c2;   // same rows at columns x-1 and x-2
    logic [2:0]    c1_eff, c2_eff;
    logic          frame_ok;
    logic          unused_low;

    // Line buffers hold the two previous rows; they are deliberately not
    // reset, frame_ok keeps stale contents out of any valid result.
    logic [H_ACTIVE-1:0] lb0;   // row y-1
    logic [H_ACTIVE-1:0] lb1;   // row y-2

    assign unused_low = ^erzhihua_data[15:0];

    assign active     = (pixel_x < H_LIM) && (pixel_y < V_LIM);
    assign idx        = pixel_x[AW-1:0];
    assign cur        = |erzhihua_data[23:16];
    assign line_start = (pixel_x == 10'd0);

    assign col = {lb1[idx], lb0[idx], cur};

    // At the start of a line the left-hand columns belong to the previous
    // line, so force them to background instead of wrapping.
    assign c1_eff = line_start ? 3'b000 : c1;
    assign c2_eff = line_start ? 3'b000 : c2;

    assign hit    = &{col, c1_eff, c2_eff};
    assign win_ok = active && (pixel_x >= 10'd2) && (pixel_y >= 10'd2) && frame_ok;

    // Read-before-write: col above sees the old contents this cycle.
    always_ff @(posedge vga_clk) begin
        if (active) begin
            lb1[idx] <= lb0[idx];
            lb0[idx] <= cur;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            c1       <= 3'b000;
            c2       <= 3'b000;
            frame_ok <= 1'b0;
        end else if (active) begin
            c1 <= col;
            c2 <= c1_eff;
            if (line_start && (pixel_y == 10'd0))
                frame_ok <= 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            erode_out   <= 12'h000;
            erode_valid <= 1'b0;
            erode_x     <= 10'd0;
            erode_y     <= 10'd0;
        end else begin
            erode_valid <= win_ok;
            erode_out   <= (win_ok && hit) ? 12'hfff : 12'h000;
            // Centre coordinates only move with a real result; they hold
            // through blanking and border samples.
            if (win_ok) begin
                erode_x <= pixel_x - 10'd1;
                erode_y <= pixel_y - 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_cov_erode.sv
module tb_cov_erode;
    localparam int H = 32;
    localparam int V = 16;

    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [9:0]  pixel_x = 10'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic [23:0] erzhihua_data = 24'd0;
    logic [11:0] erode_out;
    logic        erode_valid;
    logic [9:0]  erode_x;
    logic [9:0]  erode_y;

    int total = 0;
    int bad   = 0;

    // bench-side model state and per-frame tallies
    bit fok = 1'b0;
    bit rst_seen;
    int n_valid, n_fff, n_valid_after_rst;
    int first_cx, first_cy, fff_cx, fff_cy;

    cov_erode #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .vga_clk       (vga_clk),
        .rst_n         (rst_n),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .erzhihua_data (erzhihua_data),
        .erode_out     (erode_out),
        .erode_valid   (erode_valid),
        .erode_x       (erode_x),
        .erode_y       (erode_y)
    );

    always #5 vga_clk = ~vga_clk;

    // Image patterns, defined directly in frame coordinates.
    function automatic bit pix(int pat, int x, int y);
        case (pat)
            0: return 1'b1;
            1: return (x == 10 && y == 8);
            2: return (x >= 20 && x <= 22 && y >= 5 && y <= 7);
            3: return !(x == 15 && y == 9);
            default: return 1'b0;
        endcase
    endfunction

    // Drive one sample at the negedge-aligned point, let the posedge capture
    // it, then compare against the image model on the following negedge.
    task automatic do_cycle(int pat, int x, int y, bit act);
        bit          ev;
        bit          all9;
        logic [11:0] eo;
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        if (act) erzhihua_data = pix(pat, x, y) ? 24'hff0000 : 24'h00ffff;
        else     erzhihua_data = 24'h000000;
        @(posedge vga_clk);
        @(negedge vga_clk);
        ev = act && x >= 2 && y >= 2 && fok;
        all9 = 1'b1;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                if (!pix(pat, x - dx, y - dy)) all9 = 1'b0;
        eo = (ev && all9) ? 12'hfff : 12'h000;
        if (act && x == 0 && y == 0) fok = 1'b1;
        total++;
        if (erode_valid !== ev || erode_out !== eo) begin
            bad++;
            $display("FAIL pixel(%0d,%0d) valid=%b out=%h expected valid=%b out=%h",
                     x, y, erode_valid, erode_out, ev, eo);
        end
        if (ev) begin
            total++;
            if (erode_x !== 10'(x - 1) || erode_y !== 10'(y - 1)) begin
                bad++;
                $display("FAIL centre(%0d,%0d) got=(%0d,%0d) expected=(%0d,%0d)",
                         x, y, erode_x, erode_y, x - 1, y - 1);
            end
            n_valid++;
            if (rst_seen) n_valid_after_rst++;
            if (first_cx < 0) begin first_cx = x - 1; first_cy = y - 1; end
            if (eo == 12'hfff) begin n_fff++; fff_cx = x - 1; fff_cy = y - 1; end
        end
    endtask

    task automatic run_frame(int pat, bit blank_lines, int rx, int ry);
        n_valid = 0; n_fff = 0; n_valid_after_rst = 0;
        first_cx = -1; first_cy = -1; fff_cx = -1; fff_cy = -1;
        rst_seen = 1'b0;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                do_cycle(pat, x, y, 1'b1);
                if (x == rx && y == ry) begin
                    rst_n = 1'b0;
                    #1;
                    total++;
                    if (erode_valid !== 1'b0 || erode_out !== 12'h000) begin
                        bad++;
                        $display("FAIL async_reset valid=%b out=%h expected 0/000",
                                 erode_valid, erode_out);
                    end
                    fok = 1'b0;
                    rst_seen = 1'b1;
                    repeat (3) @(negedge vga_clk);
                    rst_n = 1'b1;
                end
            end
            // horizontal blanking, zero data that must not reach the buffers
            do_cycle(pat, 700, y, 1'b0);
            do_cycle(pat, 701, y, 1'b0);
            if (blank_lines)
                for (int x = 0; x < H; x++) do_cycle(pat, x, 500, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge vga_clk);
        total++;
        if (erode_out !== 12'h000 || erode_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out out=%h valid=%b expected 000/0", erode_out, erode_valid);
        end
        total++;
        if (erode_x !== 10'd0 || erode_y !== 10'd0) begin
            bad++;
            $display("FAIL reset_xy x=%0d y=%0d expected 0/0", erode_x, erode_y);
        end
        rst_n = 1'b1;
        fok = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic test_all_ones();
        run_frame(0, 1'b0, -1, -1);
        total++;
        if (n_fff !== 420 || n_valid !== 420) begin
            bad++;
            $display("FAIL all_ones fff=%0d valid=%0d expected 420/420", n_fff, n_valid);
        end
        total++;
        if (first_cx !== 1 || first_cy !== 1) begin
            bad++;
            $display("FAIL all_ones_first got=(%0d,%0d) expected=(1,1)", first_cx, first_cy);
        end
    endtask

    task automatic test_single_pixel();
        run_frame(1, 1'b0, -1, -1);
        total++;
        if (n_fff !== 0 || n_valid !== 420) begin
            bad++;
            $display("FAIL single_pixel fff=%0d valid=%0d expected 0/420", n_fff, n_valid);
        end
    endtask

    task automatic test_block();
        run_frame(2, 1'b0, -1, -1);
        total++;
        if (n_fff !== 1 || fff_cx !== 21 || fff_cy !== 6) begin
            bad++;
            $display("FAIL block fff=%0d at (%0d,%0d) expected 1 at (21,6)", n_fff, fff_cx, fff_cy);
        end
    endtask

    task automatic test_hole();
        run_frame(3, 1'b0, -1, -1);
        total++;
        if (n_fff !== 411 || (n_valid - n_fff) !== 9) begin
            bad++;
            $display("FAIL hole fff=%0d zeros=%0d expected 411/9", n_fff, n_valid - n_fff);
        end
    endtask

    task automatic test_blanking();
        run_frame(0, 1'b1, -1, -1);
        total++;
        if (n_fff !== 420) begin
            bad++;
            $display("FAIL blanking fff=%0d expected 420", n_fff);
        end
    endtask

    task automatic test_mid_reset();
        run_frame(0, 1'b0, 16, 8);
        total++;
        if (n_valid_after_rst !== 0) begin
            bad++;
            $display("FAIL mid_reset valid_after=%0d expected 0", n_valid_after_rst);
        end
        run_frame(0, 1'b0, -1, -1);
        total++;
        if (n_fff !== 420 || first_cx !== 1 || first_cy !== 1) begin
            bad++;
            $display("FAIL mid_reset_recover fff=%0d first=(%0d,%0d) expected 420 (1,1)",
                     n_fff, first_cx, first_cy);
        end
    endtask

    initial begin
        @(negedge vga_clk);
        test_reset();
        test_all_ones();
        test_single_pixel();
        test_block();
        test_hole();
        test_blanking();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
